// File: rtl/hpdcache_req_arb_buf_if.sv
// Handshake bundle between N requesters, the arbitration buffer and its consumer.
// The slave modport is the buffer's view; the master modport is the environment's view.
interface hpdcache_req_arb_buf_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_id;

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/hpdcache_req_arb_buf.sv
// Fixed-priority arbiter (port 0 highest) feeding a 2-entry output buffer.
// Requester ready depends only on req_valid and registered state, never on out_ready.
module hpdcache_req_arb_buf #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 32
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    hpdcache_req_arb_buf_if.slave bus
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic [W-1:0]   gnt_data;

    logic [W-1:0]   mem_data [2];
    logic [IDW-1:0] mem_id   [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;

    logic space;
    logic push;
    logic pop;

    // Lowest-index valid wins; the same loop selects its id and payload.
    always_comb begin
        gnt      = '0;
        gnt_id   = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.req_valid[i] && (gnt == '0)) begin
                gnt[i]   = 1'b1;
                gnt_id   = IDW'(i);
                gnt_data = bus.req_data[i*W +: W];
            end
        end
    end

    assign space         = (count != 2'd2);
    assign bus.req_ready = gnt & {N{space}};
    assign push          = |(bus.req_valid & bus.req_ready);
    assign bus.out_valid = (count != 2'd0);
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.out_data  = mem_data[rd_ptr];
    assign bus.out_id    = mem_id[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_id[0]   <= '0;
            mem_id[1]   <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= gnt_data;
                mem_id[wr_ptr]   <= gnt_id;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(bus.req_ready));
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= 2'd2);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (count == 2'd2)));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && (count == 2'd0)));
`endif
endmodule

// File: tb/tb_hpdcache_req_arb_buf.sv
// Bench for hpdcache_req_arb_buf: grant table, directed corner sequences and
// random traffic, with a queue scoreboard holding accepted requests until they emerge.
module tb_hpdcache_req_arb_buf;
    localparam int unsigned N   = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned IDW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hpdcache_req_arb_buf_if #(.N(N), .W(W)) bus ();

    hpdcache_req_arb_buf #(.N(N), .W(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected {id,data} pushed on acceptance, popped on delivery.
    logic [IDW+W-1:0] sb [$];

    always @(negedge clk) begin
        logic [N-1:0]     exp_ready;
        logic             found;
        logic [IDW+W-1:0] e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            exp_ready = '0;
            found     = 1'b0;
            if (sb.size() != 2) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.req_valid[i] && !found) begin
                        exp_ready[i] = 1'b1;
                        found        = 1'b1;
                    end
                end
            end
            chk("mon_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("mon_out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("mon_unexpected_pop", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("mon_data", 64'(bus.out_data), 64'(e[W-1:0]));
                    chk("mon_id", 64'(bus.out_id), 64'(e[IDW+W-1:W]));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i])
                    sb.push_back({IDW'(i), bus.req_data[i*W +: W]});
            end
        end
    end

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp_ready;
    } vec_t;

    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] acc;

        tbl[0] = '{4'b0001, 4'b0001};
        tbl[1] = '{4'b0010, 4'b0010};
        tbl[2] = '{4'b0110, 4'b0010};
        tbl[3] = '{4'b1100, 4'b0100};
        tbl[4] = '{4'b1000, 4'b1000};
        tbl[5] = '{4'b1111, 4'b0001};
        tbl[6] = '{4'b0000, 4'b0000};
        tbl[7] = '{4'b1010, 4'b0010};
        tbl[8] = '{4'b0101, 4'b0001};

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
            chk("idle_ready", 64'(bus.req_ready), 64'd0);
            chk("idle_out_id", 64'(bus.out_id), 64'd0);
        end
        step();

        // Grant table with a free-flowing consumer
        bus.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.req_valid = tbl[k].valid;
            for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 32'hB000 + 32'(k*16 + i);
            @(negedge clk);
            chk("tbl_ready", 64'(bus.req_ready), 64'(tbl[k].exp_ready));
            step();
        end
        bus.req_valid = '0;
        repeat (3) step();

        // Two simultaneous requesters: port 1 then port 2
        bus.req_valid = 4'b0110;
        bus.req_data[1*W +: W] = 32'hA1;
        bus.req_data[2*W +: W] = 32'hA2;
        @(negedge clk);
        chk("pri_ready_t", 64'(bus.req_ready), 64'b0010);
        step();
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("pri_valid_t1", 64'(bus.out_valid), 64'd1);
        chk("pri_data_t1", 64'(bus.out_data), 64'hA1);
        chk("pri_id_t1", 64'(bus.out_id), 64'd1);
        chk("pri_ready_t1", 64'(bus.req_ready), 64'b0100);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("pri_data_t2", 64'(bus.out_data), 64'hA2);
        chk("pri_id_t2", 64'(bus.out_id), 64'd2);
        step();
        @(negedge clk);
        chk("pri_drained", 64'(bus.out_valid), 64'd0);
        step();

        // Back-pressure: port 3 streams 0x10..0x12 with consumer stalled
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1000;
        bus.req_data[3*W +: W] = 32'h10;
        @(negedge clk);
        chk("bp_ready0", 64'(bus.req_ready), 64'b1000);
        step();
        bus.req_data[3*W +: W] = 32'h11;
        @(negedge clk);
        chk("bp_ready1", 64'(bus.req_ready), 64'b1000);
        step();
        bus.req_data[3*W +: W] = 32'h12;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_full_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_hold_data", 64'(bus.out_data), 64'h10);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_out0", 64'(bus.out_data), 64'h10);
        chk("bp_pop_full_ready", 64'(bus.req_ready), 64'd0);
        step();
        @(negedge clk);
        chk("bp_out1", 64'(bus.out_data), 64'h11);
        chk("bp_accept_last", 64'(bus.req_ready), 64'b1000);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("bp_out2", 64'(bus.out_data), 64'h12);
        step();
        @(negedge clk);
        chk("bp_drained", 64'(bus.out_valid), 64'd0);
        step();

        // Full buffer with a simultaneous pop: pop only, then accept
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_data[0*W +: W] = 32'h20;
        step();
        bus.req_data[0*W +: W] = 32'h21;
        step();
        bus.req_data[0*W +: W] = 32'h22;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("fp_ready_full", 64'(bus.req_ready), 64'd0);
        chk("fp_head", 64'(bus.out_data), 64'h20);
        step();
        @(negedge clk);
        chk("fp_ready_after", 64'(bus.req_ready), 64'b0001);
        chk("fp_head2", 64'(bus.out_data), 64'h21);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("fp_count1_valid", 64'(bus.out_valid), 64'd1);
        chk("fp_head3", 64'(bus.out_data), 64'h22);
        step();
        @(negedge clk);
        chk("fp_empty", 64'(bus.out_valid), 64'd0);
        step();

        // Asynchronous reset with a full buffer
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0100;
        bus.req_data[2*W +: W] = 32'h30;
        step();
        bus.req_data[2*W +: W] = 32'h31;
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_async_data", 64'(bus.out_data), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0010;
        bus.req_data[1*W +: W] = 32'h40;
        @(negedge clk);
        chk("rst_post_ready", 64'(bus.req_ready), 64'b0010);
        step();
        bus.req_valid = '0;
        @(negedge clk);
        chk("rst_post_data", 64'(bus.out_data), 64'h40);
        chk("rst_post_id", 64'(bus.out_id), 64'd1);
        step();
        @(negedge clk);
        chk("rst_no_stale", 64'(bus.out_valid), 64'd0);
        step();

        // Random traffic; requesters hold valid/data until accepted
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || acc[i]) begin
                    bus.req_valid[i]       = ($urandom_range(0, 2) != 0);
                    bus.req_data[i*W +: W] = $urandom;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        step();
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (4) step();
        chk("rand_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
